// File: rtl/path_batch_ctrl_pkg.sv
// Shared types and defaults for the Monte Carlo path batch controller.
// FP12 prices are non-negative, so magnitude order is plain unsigned order of the bits.
package path_batch_ctrl_pkg;

  localparam int FP12_W          = 12;
  localparam int DEF_NUM_OF_DAYS = 8;
  localparam int DEF_NUM_PATHS   = 16;
  localparam int DEF_CNT_W       = 8;

  typedef logic [FP12_W-1:0] fp12_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } state_e;

  // Sign bit is always 0, so an unsigned compare orders prices correctly.
  function automatic logic fp12_ge(input fp12_t a, input fp12_t b);
    return a >= b;
  endfunction

endpackage

// File: rtl/path_batch_ctrl_if.sv
// Control, generator-stream and result signals of the batch controller.
// master = requester/generator side, slave = the controller itself.
interface path_batch_ctrl_if
  import path_batch_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             run;
  fp12_t            strike;
  fp12_t            barrier;
  logic             gen_start;
  logic             path_valid;
  fp12_t            path;
  logic             busy;
  logic             path_done;
  fp12_t            last_price;
  fp12_t            path_max;
  logic             knocked;
  logic [CNT_W-1:0] itm_count;
  logic [CNT_W-1:0] ko_count;
  logic             batch_done;

  modport master (
    output run, strike, barrier, path_valid, path,
    input  gen_start, busy, path_done, last_price, path_max, knocked,
           itm_count, ko_count, batch_done
  );

  modport slave (
    input  run, strike, barrier, path_valid, path,
    output gen_start, busy, path_done, last_price, path_max, knocked,
           itm_count, ko_count, batch_done
  );

endinterface

// File: rtl/path_batch_ctrl_path_stat.sv
// Per-path statistics: running maximum, latest sample and knock-out flag,
// plus the barrier and strike compares that classify the path.
module path_stat
  import path_batch_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  load,
  input  logic  update,
  input  fp12_t sample_i,
  input  fp12_t barrier_i,
  input  fp12_t strike_i,
  output fp12_t max_o,
  output fp12_t last_o,
  output logic  ko_o,
  output logic  itm_o
);

  fp12_t max_q, max_d;
  fp12_t last_q, last_d;
  logic  ko_q, ko_d;
  logic  hit_barrier;

  assign hit_barrier = fp12_ge(sample_i, barrier_i);

  always_comb begin
    max_d  = max_q;
    last_d = last_q;
    ko_d   = ko_q;
    if (clear) begin
      max_d  = '0;
      last_d = '0;
      ko_d   = 1'b0;
    end else if (load) begin
      max_d  = sample_i;
      last_d = sample_i;
      ko_d   = hit_barrier;
    end else if (update) begin
      if (sample_i > max_q) begin
        max_d = sample_i;
      end
      last_d = sample_i;
      ko_d   = ko_q | hit_barrier;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q  <= '0;
      last_q <= '0;
      ko_q   <= 1'b0;
    end else begin
      max_q  <= max_d;
      last_q <= last_d;
      ko_q   <= ko_d;
    end
  end

  assign max_o  = max_q;
  assign last_o = last_q;
  assign ko_o   = ko_q;
  // Landing exactly on the strike is not in the money.
  assign itm_o  = !ko_q && (last_q > strike_i);

endmodule

// File: rtl/path_batch_ctrl.sv
// Batch controller: issues generator starts, consumes NUM_OF_DAYS samples per path,
// publishes per-path results and keeps saturating in-the-money / knock-out counters.
module path_batch_ctrl
  import path_batch_ctrl_pkg::*;
#(
  parameter int NUM_OF_DAYS = DEF_NUM_OF_DAYS,
  parameter int NUM_PATHS   = DEF_NUM_PATHS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst_n,
  path_batch_ctrl_if.slave bus
);

  localparam int DAY_W = (NUM_OF_DAYS > 1) ? $clog2(NUM_OF_DAYS) : 1;
  localparam logic [DAY_W-1:0] LAST_DAY  = DAY_W'(NUM_OF_DAYS - 1);
  localparam logic [CNT_W-1:0] LAST_PATH = CNT_W'(NUM_PATHS);

  state_e           state_q, state_d;
  logic             fin_q, fin_d;
  logic             tail_q, tail_d;
  logic [DAY_W-1:0] day_q;
  logic [CNT_W-1:0] path_cnt_q;
  fp12_t            strike_q, barrier_q;
  fp12_t            last_price_q, path_max_q;
  logic             knocked_q;
  logic             path_done_q;
  logic [CNT_W-1:0] itm_cnt_q, ko_cnt_q;

  logic  accept, issue, load, update, commit;
  fp12_t stat_max, stat_last;
  logic  stat_ko, stat_itm;

  path_stat u_stat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .load      (load),
    .update    (update),
    .sample_i  (bus.path),
    .barrier_i (barrier_q),
    .strike_i  (strike_q),
    .max_o     (stat_max),
    .last_o    (stat_last),
    .ko_o      (stat_ko),
    .itm_o     (stat_itm)
  );

  // fin_q marks the cycle after the last sample, where results are committed;
  // tail_q holds RECV one more cycle after the final commit so DONE follows path_done.
  always_comb begin
    state_d = state_q;
    fin_d   = fin_q;
    tail_d  = tail_q;
    accept  = 1'b0;
    issue   = 1'b0;
    load    = 1'b0;
    update  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue   = 1'b1;
        fin_d   = 1'b0;
        tail_d  = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.path_valid) begin
          load    = 1'b1;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (tail_q) begin
          tail_d  = 1'b0;
          state_d = ST_DONE;
        end else if (fin_q) begin
          commit = 1'b1;
          fin_d  = 1'b0;
          if (path_cnt_q == LAST_PATH) begin
            tail_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (bus.path_valid) begin
          update = 1'b1;
          if (day_q == LAST_DAY) begin
            fin_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fin_q        <= 1'b0;
      tail_q       <= 1'b0;
      day_q        <= '0;
      path_cnt_q   <= '0;
      strike_q     <= '0;
      barrier_q    <= '0;
      last_price_q <= '0;
      path_max_q   <= '0;
      knocked_q    <= 1'b0;
      path_done_q  <= 1'b0;
      itm_cnt_q    <= '0;
      ko_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      fin_q       <= fin_d;
      tail_q      <= tail_d;
      path_done_q <= commit;
      if (accept) begin
        strike_q   <= bus.strike;
        barrier_q  <= bus.barrier;
        path_cnt_q <= '0;
        itm_cnt_q  <= '0;
        ko_cnt_q   <= '0;
      end
      if (issue) begin
        path_cnt_q <= path_cnt_q + CNT_W'(1);
      end
      if (load) begin
        day_q <= DAY_W'(1);
      end else if (update) begin
        day_q <= day_q + DAY_W'(1);
      end
      // Counters stop at all-ones rather than wrapping.
      if (commit) begin
        last_price_q <= stat_last;
        path_max_q   <= stat_max;
        knocked_q    <= stat_ko;
        if (stat_itm && (itm_cnt_q != '1)) begin
          itm_cnt_q <= itm_cnt_q + CNT_W'(1);
        end
        if (stat_ko && (ko_cnt_q != '1)) begin
          ko_cnt_q <= ko_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.gen_start  = (state_q == ST_ISSUE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.batch_done = (state_q == ST_DONE);
  assign bus.path_done  = path_done_q;
  assign bus.last_price = last_price_q;
  assign bus.path_max   = path_max_q;
  assign bus.knocked    = knocked_q;
  assign bus.itm_count  = itm_cnt_q;
  assign bus.ko_count   = ko_cnt_q;

endmodule

// File: tb/tb_path_batch_ctrl.sv
// Directed bench: a single-path controller and a 16-path controller share one
// stimulus stream; a simple generator model with latency 3 feeds the selected one.
module tb_path_batch_ctrl;
  import path_batch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, path_valid;
  logic [11:0] strike, barrier, path;
  bit          sel16;

  int checks   = 0;
  int failures = 0;
  int gs16 = 0, pd16 = 0, solo16 = 0;

  always #5 clk = ~clk;

  path_batch_ctrl_if #(.CNT_W(8)) if1 ();
  path_batch_ctrl_if #(.CNT_W(8)) if16 ();

  assign if1.run         = run;
  assign if1.strike      = strike;
  assign if1.barrier     = barrier;
  assign if1.path_valid  = path_valid;
  assign if1.path        = path;
  assign if16.run        = run;
  assign if16.strike     = strike;
  assign if16.barrier    = barrier;
  assign if16.path_valid = path_valid;
  assign if16.path       = path;

  path_batch_ctrl #(.NUM_OF_DAYS(8), .NUM_PATHS(1), .CNT_W(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  path_batch_ctrl #(.NUM_OF_DAYS(8), .NUM_PATHS(16), .CNT_W(8)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  logic gs_sel;
  assign gs_sel = sel16 ? if16.gen_start : if1.gen_start;

  always @(negedge clk) begin
    if (if16.gen_start) gs16++;
    if (if16.path_done) pd16++;
    if (if16.gen_start && !if16.path_done) solo16++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Wait for gen_start, then after 3 cycles stream 8 samples, optionally with a gap.
  task automatic gen_path(input logic [7:0][11:0] s, input int gap_day, input int gap_len,
                          input bit poke_run);
    int n = 0;
    while (!gs_sel && n < 40) begin
      tick();
      n++;
    end
    chk("gen_start_seen", {31'd0, gs_sel}, 32'd1);
    repeat (3) begin
      run = poke_run;
      tick();
    end
    run = 1'b0;
    for (int d = 0; d < 8; d++) begin
      if (d == gap_day) begin
        path_valid = 1'b0;
        repeat (gap_len) tick();
      end
      path       = s[d];
      path_valid = 1'b1;
      tick();
    end
    path_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][11:0] s;
    int gs0, pd0, solo0;

    rst_n = 1'b0; run = 1'b0; path_valid = 1'b0; path = '0;
    strike = '0; barrier = '0; sel16 = 1'b0;
    repeat (3) tick();

    chk("rst_busy",       {31'd0, if16.busy},       32'd0);
    chk("rst_gen_start",  {31'd0, if16.gen_start},  32'd0);
    chk("rst_path_done",  {31'd0, if16.path_done},  32'd0);
    chk("rst_batch_done", {31'd0, if16.batch_done}, 32'd0);
    chk("rst_last_price", {20'd0, if16.last_price}, 32'd0);
    chk("rst_path_max",   {20'd0, if16.path_max},   32'd0);
    chk("rst_knocked",    {31'd0, if16.knocked},    32'd0);
    chk("rst_itm",        {24'd0, if16.itm_count},  32'd0);
    chk("rst_ko",         {24'd0, if16.ko_count},   32'd0);
    rst_n = 1'b1;
    tick();

    // Single path, rising samples 410..480, K=400 B=600.
    strike = 12'h400; barrier = 12'h600; sel16 = 1'b0;
    for (int d = 0; d < 8; d++) s[d] = 12'h410 + 12'(d * 16);
    start_batch();
    chk("s1_gen_start", {31'd0, if1.gen_start}, 32'd1);
    chk("s1_busy",      {31'd0, if1.busy},      32'd1);
    gen_path(s, -1, 0, 1'b0);
    tick();
    chk("s1_path_done",  {31'd0, if1.path_done},  32'd1);
    chk("s1_last_price", {20'd0, if1.last_price}, 32'h480);
    chk("s1_path_max",   {20'd0, if1.path_max},   32'h480);
    chk("s1_knocked",    {31'd0, if1.knocked},    32'd0);
    chk("s1_itm",        {24'd0, if1.itm_count},  32'd1);
    chk("s1_ko",         {24'd0, if1.ko_count},   32'd0);
    chk("s1_no_bd_yet",  {31'd0, if1.batch_done}, 32'd0);
    tick();
    chk("s1_batch_done", {31'd0, if1.batch_done}, 32'd1);
    chk("s1_busy_done",  {31'd0, if1.busy},       32'd1);
    chk("s1_pd_pulse",   {31'd0, if1.path_done},  32'd0);
    tick();
    chk("s1_idle_busy",  {31'd0, if1.busy},       32'd0);
    chk("s1_bd_pulse",   {31'd0, if1.batch_done}, 32'd0);
    chk("s1_itm_hold",   {24'd0, if1.itm_count},  32'd1);

    // Barrier equality on day 3, last sample 500.
    for (int d = 0; d < 8; d++) s[d] = 12'h410 + 12'(d * 16);
    s[3] = 12'h600;
    s[7] = 12'h500;
    start_batch();
    chk("s2_itm_cleared", {24'd0, if1.itm_count}, 32'd0);
    gen_path(s, -1, 0, 1'b0);
    tick();
    chk("s2_knocked",    {31'd0, if1.knocked},    32'd1);
    chk("s2_ko",         {24'd0, if1.ko_count},   32'd1);
    chk("s2_itm",        {24'd0, if1.itm_count},  32'd0);
    chk("s2_path_max",   {20'd0, if1.path_max},   32'h600);
    chk("s2_last_price", {20'd0, if1.last_price}, 32'h500);
    repeat (2) tick();

    // Strike equality: last sample == K, below barrier.
    for (int d = 0; d < 7; d++) s[d] = 12'h380 + 12'(d * 16);
    s[7] = 12'h400;
    start_batch();
    gen_path(s, -1, 0, 1'b0);
    tick();
    chk("s3_path_done",  {31'd0, if1.path_done},  32'd1);
    chk("s3_itm",        {24'd0, if1.itm_count},  32'd0);
    chk("s3_ko",         {24'd0, if1.ko_count},   32'd0);
    chk("s3_knocked",    {31'd0, if1.knocked},    32'd0);
    chk("s3_last_price", {20'd0, if1.last_price}, 32'h400);
    repeat (2) tick();

    // 16 back-to-back paths: 4 knocked, 4 in the money, 4 OTM, 4 at strike.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    sel16 = 1'b1;
    gs0 = gs16; pd0 = pd16; solo0 = solo16;
    start_batch();
    for (int p = 0; p < 16; p++) begin
      for (int d = 0; d < 8; d++) s[d] = 12'h300 + 12'(d * 16);
      case (p % 4)
        0: begin s[3] = 12'h650; s[7] = 12'h500; end
        1: s[7] = 12'h480;
        2: s[7] = 12'h300;
        default: s[7] = 12'h400;
      endcase
      gen_path(s, (p == 5) ? 4 : -1, 2, (p == 2));
    end
    tick();
    chk("b2b_path_done",  {31'd0, if16.path_done},  32'd1);
    chk("b2b_last_price", {20'd0, if16.last_price}, 32'h400);
    chk("b2b_path_max",   {20'd0, if16.path_max},   32'h400);
    chk("b2b_knocked",    {31'd0, if16.knocked},    32'd0);
    chk("b2b_itm",        {24'd0, if16.itm_count},  32'd4);
    chk("b2b_ko",         {24'd0, if16.ko_count},   32'd4);
    chk("b2b_no_gs_last", {31'd0, if16.gen_start},  32'd0);
    tick();
    chk("b2b_batch_done", {31'd0, if16.batch_done}, 32'd1);
    chk("b2b_busy_done",  {31'd0, if16.busy},       32'd1);
    tick();
    chk("b2b_idle",       {31'd0, if16.busy},       32'd0);
    chk("b2b_gs_count",   32'(gs16 - gs0),          32'd16);
    chk("b2b_pd_count",   32'(pd16 - pd0),          32'd16);
    chk("b2b_gs_solo",    32'(solo16 - solo0),      32'd1);

    // Reset mid-RECV on day 4, then a stale stream tail.
    start_batch();
    repeat (3) tick();
    for (int d = 0; d < 5; d++) begin
      path       = 12'h300 + 12'(d * 16);
      path_valid = 1'b1;
      if (d < 4) tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",       {31'd0, if16.busy},       32'd0);
    chk("mid_rst_gen_start",  {31'd0, if16.gen_start},  32'd0);
    chk("mid_rst_last_price", {20'd0, if16.last_price}, 32'd0);
    chk("mid_rst_path_max",   {20'd0, if16.path_max},   32'd0);
    chk("mid_rst_itm",        {24'd0, if16.itm_count},  32'd0);
    tick();
    rst_n = 1'b1;
    pd0 = pd16;
    for (int d = 5; d < 8; d++) begin
      path       = 12'h300 + 12'(d * 16);
      path_valid = 1'b1;
      tick();
    end
    path_valid = 1'b0;
    repeat (8) tick();
    chk("stale_no_path_done", 32'(pd16 - pd0),     32'd0);
    chk("stale_idle",         {31'd0, if16.busy},  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
